// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard.
package fwd_pkg;

    localparam int unsigned FWD_ADDR_W = 5;
    localparam int unsigned FWD_LAT_W  = 2;
    localparam int unsigned FWD_DEPTH  = 3;

    // fwd_src code meaning "take the register file"
    localparam int unsigned FWD_SRC_RF = 0;

    // Issue latencies of the two producer classes
    localparam int unsigned ALU_LAT  = 1;
    localparam int unsigned LOAD_LAT = 2;

    // Width of a fwd_src field: codes 0..depth
    function automatic int unsigned fwd_sel_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned SEL_W = fwd_sel_w(FWD_DEPTH);

    // One in-flight write tag, at the default widths
    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [FWD_ADDR_W-1:0] waddr;
        logic [FWD_LAT_W-1:0]  cnt;
    } fwd_slot_t;

endpackage

// File: rtl/fwd_port_match.sv
// Per-read-port lookup: youngest matching producer, readiness, data mux, stall.
module fwd_port_match
    import fwd_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned SRC_W  = 2
) (
    input  logic                    i_used,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [DATA_W-1:0]       i_rf_data,
    input  logic [DEPTH-1:0]        i_valid,
    input  logic [DEPTH-1:0]        i_wen,
    input  logic [DEPTH-1:0]        i_ready,
    input  logic [DEPTH*ADDR_W-1:0] i_waddr,
    input  logic [DEPTH*DATA_W-1:0] i_stage_data,
    output logic [DATA_W-1:0]       o_op_data,
    output logic [SRC_W-1:0]        o_fwd_src,
    output logic                    o_stall
);

    logic [DEPTH-1:0] w_match;
    logic             w_hit;

    // Per-slot address match; register 0 never matches
    always_comb begin
        w_match = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_match[k] = i_used && i_valid[k] && i_wen[k] &&
                         (i_waddr[k*ADDR_W +: ADDR_W] == i_addr) && (i_addr != '0);
        end
    end

    // Youngest match decides: forward if ready, otherwise stall (never fall back to older)
    always_comb begin
        w_hit     = 1'b0;
        o_fwd_src = SRC_W'(FWD_SRC_RF);
        o_op_data = i_rf_data;
        o_stall   = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_match[k] && !w_hit) begin
                w_hit = 1'b1;
                if (i_ready[k]) begin
                    o_fwd_src = SRC_W'(k + 1);
                    o_op_data = i_stage_data[k*DATA_W +: DATA_W];
                end else begin
                    o_stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight writes from ID to retirement.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned ADDR_W = FWD_ADDR_W,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned DEPTH  = FWD_DEPTH,
    parameter int unsigned LAT_W  = FWD_LAT_W,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned SRC_W = fwd_sel_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_en,
    input  logic                     flush,
    input  logic                     issue_valid,
    input  logic                     issue_wen,
    input  logic [ADDR_W-1:0]        issue_waddr,
    input  logic [LAT_W-1:0]         issue_lat,
    input  logic [NUM_RD-1:0]        rd_used,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD*DATA_W-1:0] rf_data,
    input  logic [DEPTH*DATA_W-1:0]  stage_data,
    output logic [NUM_RD*DATA_W-1:0] op_data,
    output logic [NUM_RD*SRC_W-1:0]  fwd_src,
    output logic                     stall,
    output logic [DEPTH-1:0]         slot_valid,
    output logic [CNT_W-1:0]         stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [ADDR_W-1:0] waddr;
        logic [LAT_W-1:0]  cnt;
    } slot_t;

    slot_t                    r_slot [DEPTH];
    slot_t                    w_next [DEPTH];
    logic [CNT_W-1:0]         r_stall_cnt;
    logic [DEPTH-1:0]         w_valid;
    logic [DEPTH-1:0]         w_wen;
    logic [DEPTH-1:0]         w_ready;
    logic [DEPTH*ADDR_W-1:0]  w_waddr;
    logic [NUM_RD-1:0]        w_port_stall;
    logic                     w_stall;
    logic                     w_issue;
    logic [LAT_W-1:0]         w_issue_cnt;
    int unsigned              w_lat_u;

    // Issue countdown: latency clamped to 1..DEPTH, minus one
    always_comb begin
        w_lat_u = 32'(issue_lat);
        if (w_lat_u == 0) begin
            w_issue_cnt = '0;
        end else if (w_lat_u > DEPTH) begin
            w_issue_cnt = LAT_W'(DEPTH - 1);
        end else begin
            w_issue_cnt = issue_lat - 1'b1;
        end
    end

    // Next slot contents: shift with saturating countdown, issue or bubble into slot0, flush kills slot1
    always_comb begin
        w_issue   = issue_valid && !w_stall && !flush;
        w_next[0] = '0;
        if (w_issue) begin
            w_next[0] = '{valid: 1'b1, wen: issue_wen, waddr: issue_waddr, cnt: w_issue_cnt};
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_next[k]     = r_slot[k-1];
            w_next[k].cnt = (r_slot[k-1].cnt == '0) ? '0 : r_slot[k-1].cnt - 1'b1;
        end
        if (flush) begin
            w_next[1].valid = 1'b0;
        end
    end

    // Slot shift register; frozen when the pipeline is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '{default: '0};
        end else if (pipe_en) begin
            r_slot <= w_next;
        end
    end

    // Flatten slot fields for the port matchers
    always_comb begin
        w_valid = '0;
        w_wen   = '0;
        w_ready = '0;
        w_waddr = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_valid[k]                   = r_slot[k].valid;
            w_wen[k]                     = r_slot[k].wen;
            w_ready[k]                   = (r_slot[k].cnt == '0);
            w_waddr[k*ADDR_W +: ADDR_W]  = r_slot[k].waddr;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_port
        fwd_port_match #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .SRC_W  (SRC_W)
        ) u_match (
            .i_used       (rd_used[r]),
            .i_addr       (rd_addr[r*ADDR_W +: ADDR_W]),
            .i_rf_data    (rf_data[r*DATA_W +: DATA_W]),
            .i_valid      (w_valid),
            .i_wen        (w_wen),
            .i_ready      (w_ready),
            .i_waddr      (w_waddr),
            .i_stage_data (stage_data),
            .o_op_data    (op_data[r*DATA_W +: DATA_W]),
            .o_fwd_src    (fwd_src[r*SRC_W +: SRC_W]),
            .o_stall      (w_port_stall[r])
        );
    end

    assign w_stall    = |w_port_stall;
    assign stall      = w_stall;
    assign slot_valid = w_valid;
    assign stall_cnt  = r_stall_cnt;

    // Saturating count of stalled advancing cycles; a flush cycle does not count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (pipe_en && w_stall && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: cycle trace table plus reset/saturation sequences.
module tb_fwd_scoreboard;
    import fwd_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 2;
    localparam int unsigned DP = 3;
    localparam int unsigned LW = 2;
    localparam int unsigned CW = 4;
    localparam int unsigned SW = SEL_W;
    localparam int unsigned NV = 32;

    localparam logic [31:0] RF0 = 32'h1111_1111;
    localparam logic [31:0] RF1 = 32'h2222_2222;
    localparam logic [31:0] ST0 = 32'hA0A0_0000;
    localparam logic [31:0] ST1 = 32'hB0B0_0001;
    localparam logic [31:0] ST2 = 32'hC0C0_0002;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             pipe_en, flush, issue_valid, issue_wen;
    logic [AW-1:0]    issue_waddr;
    logic [LW-1:0]    issue_lat;
    logic [NR-1:0]    rd_used;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rf_data;
    logic [DP*DW-1:0] stage_data;
    logic [NR*DW-1:0] op_data;
    logic [NR*SW-1:0] fwd_src;
    logic             stall;
    logic [DP-1:0]    slot_valid;
    logic [CW-1:0]    stall_cnt;

    fwd_scoreboard #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .NUM_RD (NR),
        .DEPTH  (DP),
        .LAT_W  (LW),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_en     (pipe_en),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_waddr (issue_waddr),
        .issue_lat   (issue_lat),
        .rd_used     (rd_used),
        .rd_addr     (rd_addr),
        .rf_data     (rf_data),
        .stage_data  (stage_data),
        .op_data     (op_data),
        .fwd_src     (fwd_src),
        .stall       (stall),
        .slot_valid  (slot_valid),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pe, fl, iv, iw;
        logic [AW-1:0] ia;
        logic [LW-1:0] il;
        logic [NR-1:0] u;
        logic [AW-1:0] a0, a1;
        logic          es;
        logic [SW-1:0] s0, s1;
        logic [DP-1:0] sv;
    } vec_t;

    vec_t vecs [NV];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt;

    function automatic vec_t mk(input int pe, fl, iv, iw, ia, il, u, a0, a1, es, s0, s1, sv);
        vec_t v;
        v.pe = pe[0]; v.fl = fl[0]; v.iv = iv[0]; v.iw = iw[0];
        v.ia = AW'(ia); v.il = LW'(il); v.u = NR'(u);
        v.a0 = AW'(a0); v.a1 = AW'(a1);
        v.es = es[0]; v.s0 = SW'(s0); v.s1 = SW'(s1); v.sv = DP'(sv);
        return v;
    endfunction

    function automatic logic [31:0] exp_op(input int port, input logic [SW-1:0] src);
        case (src)
            2'd1:    return ST0;
            2'd2:    return ST1;
            2'd3:    return ST2;
            default: return (port == 0) ? RF0 : RF1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pe, fl, iv, iw, input int ia, il, u, a0, a1);
        pipe_en     = pe;
        flush       = fl;
        issue_valid = iv;
        issue_wen   = iw;
        issue_waddr = AW'(ia);
        issue_lat   = LW'(il);
        rd_used     = NR'(u);
        rd_addr     = {AW'(a1), AW'(a0)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // pe fl iv iw ia il u a0 a1 | es s0 s1 sv
        vecs[0]  = mk(1,0,1,1, 3,ALU_LAT, 0, 0, 0, 0,0,0,3'b000);
        vecs[1]  = mk(1,0,1,1, 4,ALU_LAT, 3, 3, 3, 0,1,1,3'b001);
        vecs[2]  = mk(1,0,1,1, 5,LOAD_LAT,0, 0, 0, 0,0,0,3'b011);
        vecs[3]  = mk(1,0,1,1, 6,ALU_LAT, 3, 5, 1, 1,0,0,3'b111);
        vecs[4]  = mk(1,0,1,1, 6,ALU_LAT, 3, 5, 1, 0,2,0,3'b110);
        vecs[5]  = mk(1,0,1,1, 7,ALU_LAT, 0, 0, 0, 0,0,0,3'b101);
        vecs[6]  = mk(1,0,1,1, 9,ALU_LAT, 0, 0, 0, 0,0,0,3'b011);
        vecs[7]  = mk(1,0,1,1, 7,LOAD_LAT,0, 0, 0, 0,0,0,3'b111);
        vecs[8]  = mk(1,0,0,0, 0,0,       1, 7, 0, 1,0,0,3'b111);
        vecs[9]  = mk(1,0,1,1, 8,ALU_LAT, 0, 0, 0, 0,0,0,3'b110);
        vecs[10] = mk(1,1,1,1,10,ALU_LAT, 1, 8, 0, 0,1,0,3'b101);
        vecs[11] = mk(1,0,0,0, 0,0,       1, 8, 0, 0,0,0,3'b000);
        vecs[12] = mk(1,0,1,1,11,LOAD_LAT,0, 0, 0, 0,0,0,3'b000);
        vecs[13] = mk(1,1,1,1,12,ALU_LAT, 1,11, 0, 1,0,0,3'b001);
        vecs[14] = mk(1,0,1,1, 0,ALU_LAT, 0, 0, 0, 0,0,0,3'b000);
        vecs[15] = mk(1,0,1,1,12,LOAD_LAT,1, 0, 0, 0,0,0,3'b001);
        vecs[16] = mk(1,0,0,0, 0,0,       0,12,12, 0,0,0,3'b011);
        vecs[17] = mk(1,0,1,0,13,ALU_LAT, 2, 0,12, 0,0,2,3'b110);
        vecs[18] = mk(1,0,0,0, 0,0,       3,13,12, 0,0,3,3'b101);
        vecs[19] = mk(1,0,1,1,14,0,       0, 0, 0, 0,0,0,3'b010);
        vecs[20] = mk(1,0,1,1,15,3,       1,14, 0, 0,1,0,3'b101);
        vecs[21] = mk(1,0,0,0, 0,0,       1,15, 0, 1,0,0,3'b011);
        vecs[22] = mk(1,0,0,0, 0,0,       1,15, 0, 1,0,0,3'b110);
        vecs[23] = mk(0,0,0,0, 0,0,       1,15, 0, 0,3,0,3'b100);
        vecs[24] = mk(0,0,1,1,16,ALU_LAT, 1,15, 0, 0,3,0,3'b100);
        vecs[25] = mk(1,0,0,0, 0,0,       1,15, 0, 0,3,0,3'b100);
        vecs[26] = mk(1,0,0,0, 0,0,       1,15, 0, 0,0,0,3'b000);
        vecs[27] = mk(1,0,1,1,17,LOAD_LAT,0, 0, 0, 0,0,0,3'b000);
        vecs[28] = mk(0,0,0,0, 0,0,       1,17, 0, 1,0,0,3'b001);
        vecs[29] = mk(0,0,0,0, 0,0,       1,17, 0, 1,0,0,3'b001);
        vecs[30] = mk(1,0,0,0, 0,0,       1,17, 0, 1,0,0,3'b001);
        vecs[31] = mk(1,0,0,0, 0,0,       1,17, 0, 0,2,0,3'b010);

        rf_data    = {RF1, RF0};
        stage_data = {ST2, ST1, ST0};
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);

        // Reset state, asserted asynchronously before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_slot_valid", 64'(slot_valid), 64'd0);
        chk("rst_stall",      64'(stall),      64'd0);
        chk("rst_stall_cnt",  64'(stall_cnt),  64'd0);
        chk("rst_fwd_src",    64'(fwd_src),    64'd0);
        chk("rst_op_data",    op_data,         {RF1, RF0});
        #10 rst_n = 1'b1;

        // Cycle trace: drive, check combinational outputs, advance
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].pe, vecs[i].fl, vecs[i].iv, vecs[i].iw, int'(vecs[i].ia),
                  int'(vecs[i].il), int'(vecs[i].u), int'(vecs[i].a0), int'(vecs[i].a1));
            #2;
            chk($sformatf("v%0d_stall", i), 64'(stall),          64'(vecs[i].es));
            chk($sformatf("v%0d_src0", i),  64'(fwd_src[1:0]),   64'(vecs[i].s0));
            chk($sformatf("v%0d_src1", i),  64'(fwd_src[3:2]),   64'(vecs[i].s1));
            chk($sformatf("v%0d_valid", i), 64'(slot_valid),     64'(vecs[i].sv));
            chk($sformatf("v%0d_op0", i),   64'(op_data[31:0]),  64'(exp_op(0, vecs[i].s0)));
            chk($sformatf("v%0d_op1", i),   64'(op_data[63:32]), 64'(exp_op(1, vecs[i].s1)));
            step();
        end
        exp_cnt = 5;
        chk("trace_stall_cnt", 64'(stall_cnt), 64'(exp_cnt));

        // Counter saturation: each lat-3 load followed by a dependent op stalls twice
        for (int it = 0; it < 6; it++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 20, 3, 0, 0, 0);
            step();
            drive(1'b1, 1'b0, 1'b1, 1'b1, 21, ALU_LAT, 1, 20, 0);
            #1;
            chk($sformatf("sat%0d_stall_a", it), 64'(stall), 64'd1);
            step();
            chk($sformatf("sat%0d_stall_b", it), 64'(stall), 64'd1);
            step();
            chk($sformatf("sat%0d_src", it), {63'd0, stall, fwd_src[1:0]}, 64'd3);
            step();
            exp_cnt = (exp_cnt + 2 > 15) ? 15 : exp_cnt + 2;
            chk($sformatf("sat%0d_cnt", it), 64'(stall_cnt), 64'(exp_cnt));
        end

        // Mid-stream reset with three valid slots
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1, ALU_LAT, 0, 0, 0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2, ALU_LAT, 0, 0, 0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3, ALU_LAT, 0, 0, 0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3, 3, 2);
        #1;
        chk("pre_rst_valid", 64'(slot_valid), 64'd7);
        chk("pre_rst_src",   64'(fwd_src),    64'({2'd2, 2'd1}));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  64'(slot_valid), 64'd0);
        chk("mid_rst_stall",  64'(stall),      64'd0);
        chk("mid_rst_cnt",    64'(stall_cnt),  64'd0);
        chk("mid_rst_src",    64'(fwd_src),    64'd0);
        chk("mid_rst_op",     op_data,         {RF1, RF0});
        #3 rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
